// File: rtl/coarse_sar_mux.sv
// Time-multiplexed successive-approximation sequencer for the coarse CDU loop.
// Shares one ladder/comparator path across CHANNELS axes, with full SAR and +/-1 LSB tracking.
module coarse_sar_mux #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned BITS     = 6,
  parameter int unsigned SETTLE   = 4,
  localparam int unsigned CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     track,
  input  logic                     cmp,
  output logic [CHW-1:0]           chsel,
  output logic [BITS-1:0]          trial,
  output logic                     busy,
  output logic                     done,
  output logic [CHW-1:0]           done_ch,
  output logic [CHANNELS*BITS-1:0] angle,
  output logic [CHANNELS-1:0]      valid
);

  localparam int unsigned KW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_COMPARE, S_DONE} state_t;
  typedef enum logic {PH_UP, PH_HOLD} phase_t;

  state_t                    state_q, state_d;
  phase_t                    phase_q, phase_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic [CHW-1:0]            chsel_q, chsel_d;
  logic [BITS-1:0]           trial_q, trial_d;
  logic [BITS-1:0]           res_q, res_d;
  logic [KW-1:0]             k_q, k_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      trk_q, trk_d;
  logic                      done_q, done_d;
  logic [CHW-1:0]            done_ch_q, done_ch_d;
  logic [CHANNELS*BITS-1:0]  angle_q, angle_d;
  logic [CHANNELS-1:0]       valid_q, valid_d;
  logic                      cmp_s1_q, cmp_s_q;
  logic [BITS-1:0]           cur_ang;
  logic [BITS-1:0]           t;

  assign cur_ang = angle_q[ch_q*BITS +: BITS];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ch_d      = ch_q;
    chsel_d   = chsel_q;
    trial_d   = trial_q;
    res_d     = res_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    trk_d     = trk_q;
    done_d    = 1'b0;
    done_ch_d = done_ch_q;
    angle_d   = angle_q;
    valid_d   = valid_q;
    t         = trial_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          ch_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        chsel_d = ch_q;
        // Tracking needs a previous full result to step from.
        trk_d   = track && valid_q[ch_q];
        if (track && valid_q[ch_q]) begin
          trial_d = cur_ang + 1'b1;
          phase_d = PH_UP;
        end else begin
          trial_d = BITS'(1) << (BITS - 1);
          k_d     = KW'(BITS - 1);
        end
        cnt_d   = CW'(SETTLE);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CW'(1)) state_d = S_COMPARE;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      S_COMPARE: begin
        if (!trk_q) begin
          if (!cmp_s_q) t[k_q] = 1'b0;
          if (k_q != '0) begin
            t[k_q - 1'b1] = 1'b1;
            k_d           = k_q - 1'b1;
            cnt_d         = CW'(SETTLE);
            state_d       = S_SETTLE;
          end else begin
            res_d   = t;
            state_d = S_DONE;
          end
          trial_d = t;
        end else if (phase_q == PH_UP) begin
          if (cmp_s_q) begin
            res_d   = trial_q;
            state_d = S_DONE;
          end else begin
            trial_d = cur_ang;
            phase_d = PH_HOLD;
            cnt_d   = CW'(SETTLE);
            state_d = S_SETTLE;
          end
        end else begin
          res_d   = cmp_s_q ? cur_ang : cur_ang - 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        angle_d[ch_q*BITS +: BITS] = res_q;
        valid_d[ch_q]              = 1'b1;
        done_d                     = 1'b1;
        done_ch_d                  = ch_q;
        if (ch_q != LAST_CH) begin
          ch_d    = ch_q + 1'b1;
          state_d = S_LOAD;
        end else if (run) begin
          ch_d    = '0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_UP;
      ch_q      <= '0;
      chsel_q   <= '0;
      trial_q   <= '0;
      res_q     <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      trk_q     <= 1'b0;
      done_q    <= 1'b0;
      done_ch_q <= '0;
      angle_q   <= '0;
      valid_q   <= '0;
      cmp_s1_q  <= 1'b0;
      cmp_s_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ch_q      <= ch_d;
      chsel_q   <= chsel_d;
      trial_q   <= trial_d;
      res_q     <= res_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      trk_q     <= trk_d;
      done_q    <= done_d;
      done_ch_q <= done_ch_d;
      angle_q   <= angle_d;
      valid_q   <= valid_d;
      cmp_s1_q  <= cmp;
      cmp_s_q   <= cmp_s1_q;
    end
  end

  assign chsel   = chsel_q;
  assign trial   = trial_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign done_ch = done_ch_q;
  assign angle   = angle_q;
  assign valid   = valid_q;

endmodule

// File: doc/coarse_sar_mux.md
# coarse_sar_mux

Time-multiplexed successive-approximation controller for the coarse CDU loop. One clock-driven sequencer is shared across `CHANNELS` gimbal axes. For each axis it:
- selects the axis's resolver channel,
- drives a trial coarse-angle code to the external ladder-switch decoder, which generates the `_DC1`..`_DCn` lines,
- waits for the summing amplifier to settle,
- reads the synchronized comparator decision.

It supports full binary-search conversion and a ±1-LSB tracking mode. It sits between the coarse analog front end (ladder, summing amp, Schmitt trigger) and the fine/readout logic.

## Interface
Parameters:
- `CHANNELS`, 3, number of multiplexed axes (≥1).
- `BITS`, 6, coarse angle resolution; angle LSB = 360°/2^BITS.
- `SETTLE`, 4, cycles waited after every trial/channel change (≥2).

Ports (`CHW` = max(1, clog2(CHANNELS))):
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; sweeps repeat while high.
- `track` in 1: tracking-mode enable; sampled at each channel LOAD.
- `cmp` in 1: comparator decision, asynchronous. 1 = actual angle ≥ trial.
- `chsel` out CHW: analog mux channel select.
- `trial` out BITS: trial angle code to the switch decoder.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when a channel result is written.
- `done_ch` out CHW: channel index qualified by `done`.
- `angle` out CHANNELS*BITS: per-channel results; channel c occupies bits [c*BITS +: BITS].
- `valid` out CHANNELS: bit c set once channel c has completed a full conversion.

## Operation
Input synchronization:
- `cmp` passes through a 2-flop synchronizer (`cmp_s`).
- Only `cmp_s` is used.

States:
- IDLE: `run`=1 → LOAD with ch=0.
- LOAD (1 cycle):
  - Drive `chsel`=ch and latch `track`.
  - Full mode (track=0 or valid[ch]=0): `trial`=100…0, bit index k=BITS-1.
  - Track mode: `trial`=angle[ch]+1 mod 2^BITS, phase=UP.
  - Load the settle counter with SETTLE; go to SETTLE.
- SETTLE: decrement the counter; at 1 → COMPARE. Exactly SETTLE cycles are spent here.
- COMPARE (1 cycle), full mode:
  - If `cmp_s`=0, clear trial[k].
  - If k>0, set trial[k-1], decrement k, reload the counter, → SETTLE.
  - Else → DONE.
- COMPARE (1 cycle), track UP:
  - `cmp_s`=1 → result = angle+1, → DONE.
  - Otherwise `trial`=angle[ch], phase=HOLD, → SETTLE.
- COMPARE (1 cycle), track HOLD:
  - `cmp_s`=1 → result = angle (unchanged).
  - Else result = angle−1 mod 2^BITS.
  - → DONE.
- DONE (1 cycle):
  - Write the result to angle[ch], set valid[ch], pulse `done` with `done_ch`=ch.
  - If ch<CHANNELS−1: ch+1 → LOAD.
  - Else if `run`=1: ch=0 → LOAD.
  - Else → IDLE.

Boundary rules:
- Wrap-around: +1 from all-ones gives 0; −1 from 0 gives all-ones. This is modular because the angle is circular.
- `run` falling mid-sweep: the sweep finishes through the last channel, then goes IDLE. No partial channel is abandoned.
- `track` changing mid-channel has no effect until the next LOAD.
- `cmp` is ignored outside COMPARE.
- `trial` and `chsel` change only in LOAD/COMPARE, never during SETTLE.

## Timing
- Reset values: state IDLE, `chsel`=0, `trial`=0, `busy`=0, `done`=0, `done_ch`=0, `angle`=0, `valid`=0, synchronizer flops 0.
- Asserting reset mid-operation clears everything immediately; partial results are discarded.
- Full conversion: 1 + BITS*(SETTLE+1) + 1 cycles per channel. Defaults give 32 cycles; a 3-channel sweep takes 96.
- Track conversion: 1 + (SETTLE+1) + 1 = 7 cycles (UP hit), or 1 + 2*(SETTLE+1) + 1 = 12 cycles.
- `angle`/`valid` update on the same edge that raises `done`.
- Comparator latency: `cmp` must be stable ≥2 cycles before COMPARE. SETTLE≥2 guarantees this relative to the last trial change.
- `busy` rises the cycle after `run` is seen in IDLE. It falls on entry to IDLE.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs 0. Assert reset during SETTLE → immediate IDLE, `valid` stays 0.
- Full SAR: channel 0 model angle 0x2B, `run` pulsed for one sweep, `track`=0 → trial sequence 0x20, 0x30, 0x28, 0x2C, 0x2A, 0x2B; `angle[0]`=0x2B; `done` at cycle 32 with `done_ch`=0.
- Multi-channel sweep: angles {0x05, 0x3F, 0x00} → `done_ch` 0, 1, 2 at cycles 32/64/96; `valid`=3'b111; then IDLE (`run` low).
- Tracking: `track`=1, valid channel with angle 0x10, model moves to 0x11 → 0x11 after 7 cycles. Model at 0x10 → holds after 12 cycles. Model at 0x0F → 0x0F.
- Wrap: tracking from 0x3F with model at 0x00 → 0x00; from 0x00 with model at 0x3F → 0x3F.
- `run` deasserted during channel 1 → channels 1 and 2 still complete, then `busy`=0; a `cmp` glitch during SETTLE does not alter the result.
